// File: rtl/filtro_iir_pkg.sv
// filtro_iir_pkg: shared types, select codes and defaults for the biquad filter
package filtro_iir_pkg;
  typedef enum logic [1:0] {IDLE, MAC, SAT} estado_t;
  localparam logic [2:0] COEF_B0 = 3'd0;
  localparam logic [2:0] COEF_B1 = 3'd1;
  localparam logic [2:0] COEF_B2 = 3'd2;
  localparam logic [2:0] COEF_A1 = 3'd3;
  localparam logic [2:0] COEF_A2 = 3'd4;
  localparam int NUM_COEF = 5;
  function automatic int acc_ancho(input int n);
    return 2 * n + 3;
  endfunction
  function automatic longint coef_defecto(input int sel, input int frac);
    return sel == 0 ? (64'sd1 <<< frac) : 64'sd0;
  endfunction
endpackage

// File: rtl/redondeo_saturacion.sv
// redondeo_saturacion: round half toward +inf, then clamp an accumulator to N signed bits
module redondeo_saturacion #(
  parameter int N     = 25,
  parameter int FRAC  = 15,
  parameter int ACC_W = 2 * N + 3
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [N-1:0]     o_y
);
  logic signed [ACC_W:0] w_suma, w_desp;
  logic w_ovf;
  assign w_suma = {i_acc[ACC_W-1], i_acc} + ((ACC_W + 1)'(1) << (FRAC - 1));
  assign w_desp = w_suma >>> FRAC;
  // out of range whenever the bits above the result sign disagree with it
  assign w_ovf = !(&w_desp[ACC_W:N-1]) && (|w_desp[ACC_W:N-1]);
  assign o_y = !w_ovf ? w_desp[N-1:0] :
               w_desp[ACC_W] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
endmodule

// File: rtl/filtro_iir_biquad_param.sv
// filtro_iir_biquad_param: run-time-coefficient Direct Form I biquad with one shared MAC
module filtro_iir_biquad_param
  import filtro_iir_pkg::*;
#(
  parameter int N     = 25,
  parameter int FRAC  = 15,
  parameter int ACC_W = acc_ancho(N)
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic signed [N-1:0]     Uk,
  input  logic                    Bandera_ADC,
  input  logic                    Modo,
  input  logic                    Limpiar,
  input  logic                    Coef_We,
  input  logic [2:0]              Coef_Sel,
  input  logic signed [N-1:0]     Coef_Dato,
  output logic signed [N-1:0]     Yk,
  output logic                    Bandera_Listo,
  output logic                    Ocupado,
  output logic                    Overrun,
  output logic signed [ACC_W-1:0] Prueba
);
  logic signed [N-1:0] r_coef [NUM_COEF];
  logic signed [N-1:0] r_x0, r_x1, r_x2, r_y1, r_y2, r_yk;
  logic signed [ACC_W-1:0] r_acc;
  estado_t r_estado;
  logic [2:0] r_idx;
  logic r_adc_prev, r_modo, r_listo, r_ocupado, r_overrun;
  logic w_inicio;
  logic signed [N-1:0] w_coef, w_dato, w_sat;
  logic signed [2*N-1:0] w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;

  assign w_inicio = Bandera_ADC & ~r_adc_prev;
  assign w_coef = r_coef[r_idx];
  assign w_dato = r_idx == COEF_B0 ? r_x0 :
                  r_idx == COEF_B1 ? r_x1 :
                  r_idx == COEF_B2 ? r_x2 :
                  r_idx == COEF_A1 ? r_y1 : r_y2;
  assign w_prod = w_coef * w_dato;
  assign w_prod_ext = {{(ACC_W-2*N){w_prod[2*N-1]}}, w_prod};

  redondeo_saturacion #(.N(N), .FRAC(FRAC), .ACC_W(ACC_W)) u_redondeo (
    .i_acc(r_acc),
    .o_y  (w_sat)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_estado   <= IDLE;
      r_idx      <= '0;
      r_adc_prev <= 1'b0;
      r_modo     <= 1'b0;
      r_listo    <= 1'b0;
      r_ocupado  <= 1'b0;
      r_overrun  <= 1'b0;
      r_acc      <= '0;
      r_yk       <= '0;
      r_x0       <= '0;
      r_x1       <= '0;
      r_x2       <= '0;
      r_y1       <= '0;
      r_y2       <= '0;
      for (int i = 0; i < NUM_COEF; i++) r_coef[i] <= N'(coef_defecto(i, FRAC));
    end else begin
      r_adc_prev <= Bandera_ADC;
      if (w_inicio && r_estado != IDLE) r_overrun <= 1'b1;
      case (r_estado)
        IDLE: begin
          r_listo   <= 1'b0;
          r_ocupado <= w_inicio;
          if (Limpiar) begin
            r_x1 <= '0;
            r_x2 <= '0;
            r_y1 <= '0;
            r_y2 <= '0;
          end
          // a start edge takes priority over a coefficient write in the same cycle
          if (w_inicio) begin
            r_x0     <= Uk;
            r_modo   <= Modo;
            r_acc    <= '0;
            r_idx    <= COEF_B0;
            r_estado <= MAC;
          end else if (Coef_We && Coef_Sel <= COEF_A2) begin
            r_coef[Coef_Sel] <= Coef_Dato;
          end
        end
        MAC: begin
          r_acc <= r_idx < COEF_A1 ? r_acc + w_prod_ext : r_acc - w_prod_ext;
          r_idx <= r_idx + 3'd1;
          if (r_idx == COEF_A2) r_estado <= SAT;
        end
        SAT: begin
          r_yk     <= r_modo ? r_x0 : w_sat;
          r_listo  <= 1'b1;
          r_estado <= IDLE;
          r_x2     <= r_modo ? '0 : r_x1;
          r_x1     <= r_modo ? '0 : r_x0;
          r_y2     <= r_modo ? '0 : r_y1;
          r_y1     <= r_modo ? '0 : w_sat;
        end
        default: r_estado <= IDLE;
      endcase
    end
  end

  assign Yk            = r_yk;
  assign Bandera_Listo = r_listo;
  assign Ocupado       = r_ocupado;
  assign Overrun       = r_overrun;
  assign Prueba        = r_acc;
endmodule

// File: tb/tb_filtro_iir_biquad_param.sv
// tb_filtro_iir_biquad_param: directed scenario tests for the parametrised biquad
module tb_filtro_iir_biquad_param;
  import filtro_iir_pkg::*;
  localparam int N = 25;
  localparam int ACC_W = 2 * N + 3;
  logic Clk = 1'b0, Reset_n = 1'b0, Bandera_ADC = 1'b0, Modo = 1'b0, Limpiar = 1'b0, Coef_We = 1'b0;
  logic signed [N-1:0] Uk = '0, Coef_Dato = '0;
  logic [2:0] Coef_Sel = '0;
  logic signed [N-1:0] Yk;
  logic Bandera_Listo, Ocupado, Overrun;
  logic signed [ACC_W-1:0] Prueba;
  int errors = 0, checks = 0;

  filtro_iir_biquad_param dut (
    .Clk(Clk), .Reset_n(Reset_n), .Uk(Uk), .Bandera_ADC(Bandera_ADC), .Modo(Modo),
    .Limpiar(Limpiar), .Coef_We(Coef_We), .Coef_Sel(Coef_Sel), .Coef_Dato(Coef_Dato),
    .Yk(Yk), .Bandera_Listo(Bandera_Listo), .Ocupado(Ocupado), .Overrun(Overrun), .Prueba(Prueba)
  );

  always #5 Clk = ~Clk;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic escribir(input logic [2:0] sel, input int d);
    Coef_Sel = sel;
    Coef_Dato = N'(d);
    Coef_We = 1'b1;
    tick();
    Coef_We = 1'b0;
  endtask

  task automatic limpiar;
    Limpiar = 1'b1;
    tick();
    Limpiar = 1'b0;
  endtask

  task automatic muestra(input int u, output logic signed [N-1:0] y, output int lat);
    Uk = N'(u);
    Bandera_ADC = 1'b1;
    tick();
    Bandera_ADC = 1'b0;
    lat = -1;
    y = 'x;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (Bandera_Listo) begin
        lat = k;
        y = Yk;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    repeat (3) tick();
    Reset_n = 1'b1;
    checks++; if (Yk !== 0) begin errors++; $display("FAIL reset_yk got %0d want 0", Yk); end
    checks++; if (Bandera_Listo !== 1'b0) begin errors++; $display("FAIL reset_listo got %b want 0", Bandera_Listo); end
    checks++; if (Ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado got %b want 0", Ocupado); end
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", Overrun); end
    checks++; if (Prueba !== 0) begin errors++; $display("FAIL reset_prueba got %0d want 0", Prueba); end
  endtask

  task automatic test_latency;
    logic exp_oc, exp_li;
    Uk = N'(1000);
    Bandera_ADC = 1'b1;
    tick();
    Bandera_ADC = 1'b0;
    checks++; if (Ocupado !== 1'b1 || Bandera_Listo !== 1'b0) begin errors++; $display("FAIL lat_k0 ocupado=%b listo=%b want 1 0", Ocupado, Bandera_Listo); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_oc = (k <= 6);
      exp_li = (k == 6);
      checks++; if (Ocupado !== exp_oc) begin errors++; $display("FAIL lat_ocupado[%0d] got %b want %b", k, Ocupado, exp_oc); end
      checks++; if (Bandera_Listo !== exp_li) begin errors++; $display("FAIL lat_listo[%0d] got %b want %b", k, Bandera_Listo, exp_li); end
      if (k == 6) begin
        checks++; if (Yk !== 1000) begin errors++; $display("FAIL lat_yk got %0d want 1000", Yk); end
        checks++; if (Prueba !== 32768000) begin errors++; $display("FAIL lat_prueba got %0d want 32768000", Prueba); end
      end
    end
  endtask

  task automatic test_fir_step;
    int e [4] = '{1000, 2000, 3000, 3000};
    logic signed [N-1:0] y;
    int lat;
    escribir(COEF_B0, 8192);
    escribir(COEF_B1, 8192);
    escribir(COEF_B2, 8192);
    limpiar();
    for (int i = 0; i < 4; i++) begin
      muestra(4000, y, lat);
      checks++; if (y !== e[i]) begin errors++; $display("FAIL step[%0d] got %0d want %0d", i, y, e[i]); end
      checks++; if (lat !== 6) begin errors++; $display("FAIL step_lat[%0d] got %0d want 6", i, lat); end
    end
  endtask

  task automatic test_iir_impulse;
    int u [4] = '{1024, 0, 0, 0};
    int e [4] = '{512, 256, 128, 64};
    logic signed [N-1:0] y;
    int lat;
    escribir(COEF_B0, 16384);
    escribir(COEF_B1, 0);
    escribir(COEF_B2, 0);
    escribir(COEF_A1, -16384);
    limpiar();
    for (int i = 0; i < 4; i++) begin
      muestra(u[i], y, lat);
      checks++; if (y !== e[i]) begin errors++; $display("FAIL impulse[%0d] got %0d want %0d", i, y, e[i]); end
    end
  endtask

  task automatic test_saturation;
    logic signed [N-1:0] y;
    int lat;
    escribir(COEF_B0, 32768);
    escribir(COEF_B1, 32768);
    escribir(COEF_A1, 0);
    limpiar();
    muestra(16777215, y, lat);
    checks++; if (y !== 16777215) begin errors++; $display("FAIL sat_pos0 got %0d want 16777215", y); end
    muestra(16777215, y, lat);
    checks++; if (y !== 16777215) begin errors++; $display("FAIL sat_pos1 got %0d want 16777215", y); end
    limpiar();
    muestra(-16777216, y, lat);
    checks++; if (y !== -16777216) begin errors++; $display("FAIL sat_neg0 got %0d want -16777216", y); end
    muestra(-16777216, y, lat);
    checks++; if (y !== -16777216) begin errors++; $display("FAIL sat_neg1 got %0d want -16777216", y); end
    checks++; if (Prueba !== -(64'sd1 <<< 40)) begin errors++; $display("FAIL sat_prueba got %0d want %0d", Prueba, -(64'sd1 <<< 40)); end
  endtask

  task automatic test_rounding;
    int u [4] = '{1, -1, 3, -3};
    int e [4] = '{1, 0, 2, -1};
    logic signed [N-1:0] y;
    int lat;
    escribir(COEF_B0, 16384);
    escribir(COEF_B1, 0);
    limpiar();
    for (int i = 0; i < 4; i++) begin
      muestra(u[i], y, lat);
      checks++; if (y !== e[i]) begin errors++; $display("FAIL round[%0d] got %0d want %0d", i, y, e[i]); end
    end
  endtask

  task automatic test_bypass;
    logic signed [N-1:0] y;
    int lat;
    Modo = 1'b1;
    muestra(1234, y, lat);
    Modo = 1'b0;
    checks++; if (y !== 1234) begin errors++; $display("FAIL bypass got %0d want 1234", y); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL bypass_lat got %0d want 6", lat); end
    escribir(COEF_B1, 32768);
    muestra(100, y, lat);
    checks++; if (y !== 50) begin errors++; $display("FAIL bypass_clean got %0d want 50", y); end
    escribir(COEF_B1, 0);
  endtask

  task automatic test_overrun;
    logic signed [N-1:0] y;
    int lat, n;
    escribir(COEF_B0, 32768);
    limpiar();
    Uk = N'(777);
    Bandera_ADC = 1'b1;
    tick();
    Bandera_ADC = 1'b0;
    Coef_Sel = COEF_B0;
    Coef_Dato = '0;
    Coef_We = 1'b1;
    n = 0;
    y = 'x;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) Coef_We = 1'b0;
      if (k == 2) Bandera_ADC = 1'b1;
      if (k == 3) Bandera_ADC = 1'b0;
      if (Bandera_Listo) begin n++; y = Yk; end
    end
    checks++; if (n !== 1) begin errors++; $display("FAIL ovr_listo_count got %0d want 1", n); end
    checks++; if (y !== 777) begin errors++; $display("FAIL ovr_yk got %0d want 777", y); end
    checks++; if (Overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", Overrun); end
    muestra(-123, y, lat);
    checks++; if (y !== -123) begin errors++; $display("FAIL ovr_coef_kept got %0d want -123", y); end
    checks++; if (Overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", Overrun); end
  endtask

  task automatic test_reset_mid;
    logic signed [N-1:0] y;
    int lat, n;
    escribir(COEF_B0, 16384);
    muestra(2000, y, lat);
    checks++; if (y !== 1000) begin errors++; $display("FAIL rmid_pre got %0d want 1000", y); end
    Uk = N'(5000);
    Bandera_ADC = 1'b1;
    tick();
    Bandera_ADC = 1'b0;
    tick();
    tick();
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    checks++; if (Yk !== 0) begin errors++; $display("FAIL rmid_yk got %0d want 0", Yk); end
    checks++; if (Ocupado !== 1'b0) begin errors++; $display("FAIL rmid_ocupado got %b want 0", Ocupado); end
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun got %b want 0", Overrun); end
    checks++; if (Prueba !== 0) begin errors++; $display("FAIL rmid_prueba got %0d want 0", Prueba); end
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (Bandera_Listo) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL rmid_no_listo got %0d want 0", n); end
    escribir(COEF_B1, 32768);
    muestra(-500, y, lat);
    checks++; if (y !== -500) begin errors++; $display("FAIL rmid_post got %0d want -500", y); end
    escribir(COEF_B1, 0);
  endtask

  task automatic test_back_to_back;
    limpiar();
    Uk = N'(11);
    Bandera_ADC = 1'b1;
    tick();
    Bandera_ADC = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 6) begin
        checks++; if (Bandera_Listo !== 1'b1 || Yk !== 11) begin errors++; $display("FAIL b2b_first listo=%b yk=%0d want 1 11", Bandera_Listo, Yk); end
        Uk = N'(22);
        Bandera_ADC = 1'b1;
      end
      if (k == 7) begin
        Bandera_ADC = 1'b0;
        checks++; if (Ocupado !== 1'b1) begin errors++; $display("FAIL b2b_restart got %b want 1", Ocupado); end
      end
      if (k == 13) begin
        checks++; if (Bandera_Listo !== 1'b1 || Yk !== 22) begin errors++; $display("FAIL b2b_second listo=%b yk=%0d want 1 22", Bandera_Listo, Yk); end
      end
    end
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", Overrun); end
    tick();
  endtask

  task automatic test_hold;
    int n;
    Uk = N'(42);
    Bandera_ADC = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (Bandera_Listo) n++;
    end
    Bandera_ADC = 1'b0;
    tick();
    checks++; if (n !== 1) begin errors++; $display("FAIL hold_count got %0d want 1", n); end
    checks++; if (Yk !== 42) begin errors++; $display("FAIL hold_yk got %0d want 42", Yk); end
    checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL hold_overrun got %b want 0", Overrun); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fir_step();
    test_iir_impulse();
    test_saturation();
    test_rounding();
    test_bypass();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/filtro_iir_biquad_param.md
Name: filtro_iir_biquad_param

Overview:
- Parametrised second-order IIR filter section (Direct Form I), successor to the fixed 200 Hz low-pass.
- Coefficients are loadable at run time, so one block serves low-pass, high-pass or band-pass roles.
- Sits between the ADC sample-ready strobe and downstream processing, same place as the current low-pass.
- Uses one time-multiplexed multiply-accumulate, with round-half-up and signed saturation on the output.

Parameters:
- N, 25, signed sample and coefficient width.
- FRAC, 15, number of fractional bits in the coefficient format (1.0 = 2^FRAC).
- ACC_W, 2*N+3, accumulator width; must not be overridden below 2*N+3.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset_n  in  1  synchronous reset, active-low.
- Uk  in  N  signed input sample; captured on the start edge.
- Bandera_ADC  in  1  sample-ready level from the ADC path; a 0->1 transition starts a computation.
- Modo  in  1  0 = filter, 1 = bypass.
- Limpiar  in  1  clears the x/y history; honoured only in IDLE.
- Coef_We  in  1  coefficient write strobe.
- Coef_Sel  in  3  coefficient select: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5-7 ignored.
- Coef_Dato  in  N  signed coefficient value, Q(N-FRAC).FRAC.
- Yk  out  N  signed filtered output, registered.
- Bandera_Listo  out  1  one-cycle pulse, coincident with a Yk update.
- Ocupado  out  1  high from the start edge until Bandera_Listo, inclusive.
- Overrun  out  1  sticky: a start edge arrived while Ocupado was high.
- Prueba  out  ACC_W  raw accumulator, for debug.

Behaviour:
- Reset (Reset_n=0 at a clock edge) clears everything, including mid-computation:
  - Yk, Bandera_Listo, Ocupado, Overrun, Prueba and history x1, x2, y1, y2 all go to 0.
  - Edge-detect register goes to 0.
  - Coefficients load defaults: b0 = 2^FRAC, all others 0 (identity).
  - An aborted computation produces no Listo pulse.
- Equation: y = b0*x0 + b1*x1 + b2*x2 - a1*y1 - a2*y2.
  - Products are full 2N-bit signed values, sign-extended to ACC_W.
- States:
  - IDLE: wait. A start edge is Bandera_ADC=1 while the previous sampled value was 0.
  - MAC: 5 cycles, index 0..4, one product per cycle in the order b0, b1, b2, a1, a2.
  - SAT: round, saturate, write Yk, update history, pulse Listo; then return to IDLE.
- Timing: start edge detected at clock edge t.
  - Uk -> x0, accumulator cleared, Ocupado=1.
  - MAC runs on edges t+1 to t+5.
  - Yk, history update and Bandera_Listo=1 occur at edge t+6; Ocupado drops at t+7.
  - Fixed latency is 6 cycles; minimum start spacing is 7 cycles.
- Rounding and saturation:
  - Add 2^(FRAC-1) to the accumulator, then arithmetic shift right by FRAC.
  - Clamp to [-2^(N-1), 2^(N-1)-1].
  - Identical for positive and negative values, i.e. round half toward +inf.
- History update in SAT: x2<=x1, x1<=x0, y2<=y1, y1<=Yk (the saturated value).
- Bypass (Modo=1 sampled at the start edge):
  - Same 6-cycle latency; Yk = Uk captured at the start edge.
  - History is cleared to 0, so re-entering filter mode starts clean.
- A start edge while Ocupado=1 is ignored and sets Overrun. Overrun clears only on reset.
- Coefficient writes:
  - Take effect on the next edge, and only in IDLE with no start edge in the same cycle.
  - Otherwise the write is dropped; the start edge wins.
- Limpiar in IDLE zeros the history next edge. If it coincides with a start edge, clear first, then compute with zero history.
- Prueba shows the accumulator, updated every MAC cycle and held otherwise.
- Bandera_ADC held high does not retrigger; a new start needs a return to 0.

Decomposition:
- Package filtro_iir_pkg holds:
  - state encoding: IDLE, MAC, SAT;
  - coefficient select codes COEF_B0..COEF_A2;
  - ACC_W derivation;
  - default coefficient constants.
- Sub-module redondeo_saturacion: combinational round-and-clamp from ACC_W to N bits, with FRAC as a parameter. Reused by future filter blocks.

Test Plan:
- Reset defaults, Uk=1000, one ADC pulse -> Yk=1000 and Bandera_Listo high for exactly one cycle, 6 cycles after the start edge; Ocupado high for 7 cycles.
- Write b0=b1=b2=8192, a1=a2=0; apply step Uk=4000 over four starts -> Yk = 1000, 2000, 3000, 3000.
- Write b0=16384, a1=-16384; impulse Uk=1024 then 0 -> Yk = 512, 256, 128, 64.
- b0=b1=32768; Uk=16777215 twice -> second Yk=16777215 (saturated). Repeat with Uk=-16777216 -> second Yk=-16777216.
- Second ADC rising edge at t+3 plus Coef_We during busy -> no extra Listo, Overrun=1 and sticky, coefficient unchanged (verify with next sample).
- Reset_n low at t+3 mid-computation -> no Listo, Yk=0, history cleared, identity coefficients restored; next Uk=-500 gives Yk=-500.
